mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory bus slave among NUM_REQ masters.
// Each grant runs IDLE -> BUSY -> RELEASE; every downstream output is registered.
// Optional build macro MEM_ARBITER_TIMEOUT_EN adds a BUSY watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles without ack_i.
module mem_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_sel_i,
    input  logic [32*NUM_REQ-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]      req_we_i,
    input  logic [4*NUM_REQ-1:0]    req_wr_mask_i,
    input  logic [32*NUM_REQ-1:0]   req_data_i,
    output logic [31:0]             req_data_o,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic                    sel_o,
    output logic [31:0]             addr_o,
    output logic                    we_o,
    output logic [3:0]              wr_mask_o,
    output logic [31:0]             data_out_o,
    input  logic [31:0]             data_in_i,
    input  logic                    ack_i,
    output logic                    timeout_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;

    logic               any_req;
    logic [IDX_W-1:0]   winner;
    int unsigned        cand;
    logic [IDX_W-1:0]   cand_idx;
    logic [31:0]        win_addr;
    logic               win_we;
    logic [3:0]         win_mask;
    logic [31:0]        win_data;
    logic [NUM_REQ-1:0] grant_onehot;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [TO_W-1:0]    to_cnt;
    logic               timeout_q;

    assign timeout_o = timeout_q;
`else
    // Without the watchdog the parameter has no effect and the pulse never fires.
    assign timeout_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        win_addr = '0;
        win_we   = 1'b0;
        win_mask = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(last_grant) + i + 1) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_req && req_sel_i[cand_idx]) begin
                any_req  = 1'b1;
                winner   = cand_idx;
                win_addr = req_addr_i[32*cand +: 32];
                win_we   = req_we_i[cand_idx];
                win_mask = req_wr_mask_i[4*cand +: 4];
                win_data = req_data_i[32*cand +: 32];
            end
        end
    end

    // One-hot ack pattern for the current grantee.
    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    // Arbitration FSM with registered downstream bus and requester-side outputs.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= StIdle;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            sel_o      <= 1'b0;
            addr_o     <= '0;
            we_o       <= 1'b0;
            wr_mask_o  <= 4'b1111;
            data_out_o <= '0;
            req_data_o <= '0;
            req_ack_o  <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            to_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (any_req) begin
                        grant      <= winner;
                        sel_o      <= 1'b1;
                        addr_o     <= win_addr;
                        we_o       <= win_we;
                        wr_mask_o  <= win_mask;
                        data_out_o <= win_data;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                        state      <= StBusy;
                    end
                end
                StBusy: begin
                    // Requester inputs are ignored here; the latched transaction always finishes.
                    if (ack_i) begin
                        sel_o      <= 1'b0;
                        we_o       <= 1'b0;
                        req_data_o <= data_in_i;
                        req_ack_o  <= grant_onehot;
                        last_grant <= grant;
                        state      <= StRelease;
                    end
`ifdef MEM_ARBITER_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        sel_o      <= 1'b0;
                        we_o       <= 1'b0;
                        req_data_o <= 32'hFFFF_FFFF;
                        req_ack_o  <= grant_onehot;
                        timeout_q  <= 1'b1;
                        last_grant <= grant;
                        state      <= StRelease;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                StRelease: begin
                    // Dead cycle lets the acked requester drop its sel before re-arbitration.
                    req_ack_o <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
